// File: rtl/parking_slot_if.sv
// parking_slot_if: sensor inputs and occupancy/door/stat outputs of the parking slot manager
interface parking_slot_if #(
  parameter int NUM_SLOTS = 8
);
  localparam int SLOT_W = $clog2(NUM_SLOTS);
  logic                 enable;
  logic                 entry_sensor;
  logic                 exit_sensor;
  logic [SLOT_W-1:0]    exit_location;
  logic [NUM_SLOTS-1:0] occupancy;
  logic [SLOT_W:0]      free_count;
  logic [SLOT_W-1:0]    best_slot;
  logic                 best_valid;
  logic                 door_open;
  logic                 full_light;
  logic                 entry_rejected;
  logic                 exit_error;
  logic [15:0]          stat_entries;
  logic [15:0]          stat_exits;
  modport master (
    output enable, entry_sensor, exit_sensor, exit_location,
    input  occupancy, free_count, best_slot, best_valid, door_open, full_light,
           entry_rejected, exit_error, stat_entries, stat_exits
  );
  modport slave (
    input  enable, entry_sensor, exit_sensor, exit_location,
    output occupancy, free_count, best_slot, best_valid, door_open, full_light,
           entry_rejected, exit_error, stat_entries, stat_exits
  );
endinterface

// File: rtl/parking_slot_manager.sv
// parking_slot_manager: slot occupancy, lowest-free allocation and timed door; PARKING_STATS_EN adds entry/exit counters
module parking_slot_manager #(
  parameter int NUM_SLOTS = 8,
  parameter int SLOT_W    = $clog2(NUM_SLOTS),
  parameter int DOOR_HOLD = 4
) (
  input logic           clk,
  input logic           reset,
  parking_slot_if.slave bus
);
  typedef enum logic {IDLE, OPEN} door_state_t;
  door_state_t          state_q;
  logic [NUM_SLOTS-1:0] occ_q, occ_d, cand, grant;
  logic [SLOT_W:0]      free_q, free_d;
  logic [7:0]           timer_q;
  logic                 door_q, full_q, rej_q, err_q;
  logic                 in_range, exit_ok, entry_ok;
  logic [SLOT_W-1:0]    best;
  // Resolve the exit first so an entry in the same cycle can reuse the freed slot
  always_comb begin
    in_range = int'(bus.exit_location) < NUM_SLOTS;
    exit_ok  = bus.exit_sensor && in_range && occ_q[bus.exit_location];
    cand     = occ_q & ~(NUM_SLOTS'(exit_ok) << bus.exit_location);
    grant    = ~cand & (cand + NUM_SLOTS'(1));
    entry_ok = bus.entry_sensor && !(&cand);
    occ_d    = entry_ok ? (cand | grant) : cand;
    free_d   = free_q + (SLOT_W+1)'(exit_ok) - (SLOT_W+1)'(entry_ok);
  end
  // Lowest free slot of the registered occupancy, for the display
  always_comb begin
    best = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) if (!occ_q[i]) best = SLOT_W'(i);
  end
  // Occupancy, free count and event pulses all advance together
  always_ff @(posedge clk)
    if (reset) begin
      occ_q  <= '0;
      free_q <= (SLOT_W+1)'(NUM_SLOTS);
      full_q <= 1'b0;
      rej_q  <= 1'b0;
      err_q  <= 1'b0;
    end else if (bus.enable) begin
      occ_q  <= occ_d;
      free_q <= free_d;
      full_q <= free_d == '0;
      rej_q  <= bus.entry_sensor && !entry_ok;
      err_q  <= bus.exit_sensor && !exit_ok;
    end
  // Door: every accepted event (re)loads the hold timer, door drops when it runs out
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      door_q  <= 1'b0;
    end else if (bus.enable) begin
      if (entry_ok || exit_ok) begin
        state_q <= OPEN;
        timer_q <= 8'(DOOR_HOLD);
        door_q  <= 1'b1;
      end else if (state_q == OPEN) begin
        timer_q <= timer_q - 8'd1;
        if (timer_q == 8'd1) begin
          state_q <= IDLE;
          door_q  <= 1'b0;
        end
      end
    end
`ifdef PARKING_STATS_EN
  logic [15:0] ent_q, ext_q;
  // Accepted entry/exit counters, wrapping at 16 bits
  always_ff @(posedge clk)
    if (reset) begin
      ent_q <= '0;
      ext_q <= '0;
    end else if (bus.enable) begin
      ent_q <= ent_q + 16'(entry_ok);
      ext_q <= ext_q + 16'(exit_ok);
    end
  assign bus.stat_entries = ent_q;
  assign bus.stat_exits   = ext_q;
`else
  assign bus.stat_entries = '0;
  assign bus.stat_exits   = '0;
`endif
  assign bus.occupancy      = occ_q;
  assign bus.free_count     = free_q;
  assign bus.best_slot      = best;
  assign bus.best_valid     = ~&occ_q;
  assign bus.door_open      = door_q;
  assign bus.full_light     = full_q;
  assign bus.entry_rejected = rej_q;
  assign bus.exit_error     = err_q;
endmodule

// File: tb/tb_parking_slot_manager.sv
// tb_parking_slot_manager: table-driven scoreboard bench for the parking slot manager
module tb_parking_slot_manager;
  typedef struct packed {
    logic       en, ent, ext;
    logic [1:0] loc;
    logic [3:0] occ;
    logic [2:0] free;
    logic       door, full, rej, err;
  } vec_t;
  typedef struct packed {
    vec_t        v;
    logic [15:0] se, sx;
  } exp_t;
  logic        clk = 1'b0;
  logic        reset;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] n_ent = '0, n_ext = '0;
  exp_t        sb[$];
  vec_t        tbl[31];
  parking_slot_if #(.NUM_SLOTS(4)) b4();
  parking_slot_if #(.NUM_SLOTS(8)) b8();
  parking_slot_manager #(.NUM_SLOTS(4), .DOOR_HOLD(3)) dut4 (.clk(clk), .reset(reset), .bus(b4.slave));
  parking_slot_manager #(.NUM_SLOTS(8), .DOOR_HOLD(3)) dut8 (.clk(clk), .reset(reset), .bus(b8.slave));
  always #5 clk = ~clk;
  function automatic vec_t mk(input int en, ent, ext, loc, occ, free, door, full, rej, err);
    mk = '{en[0], ent[0], ext[0], loc[1:0], occ[3:0], free[2:0], door[0], full[0], rej[0], err[0]};
  endfunction
  function automatic logic [1:0] low_free(input logic [3:0] o);
    low_free = !o[0] ? 2'd0 : !o[1] ? 2'd1 : !o[2] ? 2'd2 : !o[3] ? 2'd3 : 2'd0;
  endfunction
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask
  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    chk("occupancy", b4.occupancy, e.v.occ);
    chk("free_count", b4.free_count, e.v.free);
    chk("door_open", b4.door_open, e.v.door);
    chk("full_light", b4.full_light, e.v.full);
    chk("entry_rejected", b4.entry_rejected, e.v.rej);
    chk("exit_error", b4.exit_error, e.v.err);
    chk("best_slot", b4.best_slot, low_free(e.v.occ));
    chk("best_valid", b4.best_valid, e.v.occ != 4'hf);
    chk("stat_entries", b4.stat_entries, e.se);
    chk("stat_exits", b4.stat_exits, e.sx);
  endtask
  task automatic step(input vec_t v);
    @(negedge clk);
    b4.enable        = v.en;
    b4.entry_sensor  = v.ent;
    b4.exit_sensor   = v.ext;
    b4.exit_location = v.loc;
`ifdef PARKING_STATS_EN
    if (v.en && v.ent && !v.rej) n_ent++;
    if (v.en && v.ext && !v.err) n_ext++;
`endif
    sb.push_back('{v, n_ent, n_ext});
    @(posedge clk);
    #1 check_out();
  endtask
  initial begin
    tbl[0]  = mk(1, 1, 0, 0, 'b0001, 3, 1, 0, 0, 0);
    tbl[1]  = mk(1, 1, 0, 0, 'b0011, 2, 1, 0, 0, 0);
    tbl[2]  = mk(1, 1, 0, 0, 'b0111, 1, 1, 0, 0, 0);
    tbl[3]  = mk(1, 1, 0, 0, 'b1111, 0, 1, 1, 0, 0);
    tbl[4]  = mk(1, 0, 0, 0, 'b1111, 0, 1, 1, 0, 0);
    tbl[5]  = mk(1, 0, 0, 0, 'b1111, 0, 1, 1, 0, 0);
    tbl[6]  = mk(1, 0, 0, 0, 'b1111, 0, 0, 1, 0, 0);
    tbl[7]  = mk(1, 1, 0, 0, 'b1111, 0, 0, 1, 1, 0);
    tbl[8]  = mk(1, 0, 0, 0, 'b1111, 0, 0, 1, 0, 0);
    tbl[9]  = mk(1, 1, 1, 2, 'b1111, 0, 1, 1, 0, 0);
    tbl[10] = mk(1, 0, 0, 0, 'b1111, 0, 1, 1, 0, 0);
    tbl[11] = mk(1, 0, 0, 0, 'b1111, 0, 1, 1, 0, 0);
    tbl[12] = mk(1, 0, 0, 0, 'b1111, 0, 0, 1, 0, 0);
    tbl[13] = mk(1, 0, 1, 1, 'b1101, 1, 1, 0, 0, 0);
    tbl[14] = mk(1, 0, 1, 3, 'b0101, 2, 1, 0, 0, 0);
    tbl[15] = mk(1, 0, 1, 1, 'b0101, 2, 1, 0, 0, 1);
    tbl[16] = mk(1, 0, 1, 2, 'b0001, 3, 1, 0, 0, 0);
    tbl[17] = mk(1, 0, 0, 0, 'b0001, 3, 1, 0, 0, 0);
    tbl[18] = mk(1, 0, 0, 0, 'b0001, 3, 1, 0, 0, 0);
    tbl[19] = mk(1, 0, 0, 0, 'b0001, 3, 0, 0, 0, 0);
    tbl[20] = mk(1, 1, 0, 0, 'b0011, 2, 1, 0, 0, 0);
    tbl[21] = mk(1, 0, 0, 0, 'b0011, 2, 1, 0, 0, 0);
    for (int i = 22; i < 27; i++) tbl[i] = mk(0, 1, 0, 0, 'b0011, 2, 1, 0, 0, 0);
    tbl[27] = mk(1, 0, 0, 0, 'b0011, 2, 1, 0, 0, 0);
    tbl[28] = mk(1, 0, 0, 0, 'b0011, 2, 0, 0, 0, 0);
    tbl[29] = mk(1, 1, 1, 0, 'b0011, 2, 1, 0, 0, 0);
    tbl[30] = mk(1, 1, 1, 3, 'b0111, 1, 1, 0, 0, 1);
    reset            = 1'b1;
    b4.enable        = 1'b0;
    b4.entry_sensor  = 1'b1;
    b4.exit_sensor   = 1'b0;
    b4.exit_location = '0;
    b8.enable        = 1'b1;
    b8.entry_sensor  = 1'b0;
    b8.exit_sensor   = 1'b0;
    b8.exit_location = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_occupancy", b4.occupancy, 4'b0000);
    chk("rst_free_count", b4.free_count, 3'd4);
    chk("rst_door_open", b4.door_open, 1'b0);
    chk("rst_full_light", b4.full_light, 1'b0);
    chk("rst_entry_rejected", b4.entry_rejected, 1'b0);
    chk("rst_exit_error", b4.exit_error, 1'b0);
    chk("rst_best_valid", b4.best_valid, 1'b1);
    chk("rst_stat_entries", b4.stat_entries, 16'd0);
    @(negedge clk);
    reset           = 1'b0;
    b4.entry_sensor = 1'b0;
    for (int i = 0; i < 31; i++) step(tbl[i]);
    @(negedge clk);
    b4.enable = 1'b1; b4.entry_sensor = 1'b0; b4.exit_sensor = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      b8.entry_sensor = 1'b1;
      @(posedge clk);
      #1 chk("occ8_fill", b8.occupancy, (64'd1 << (i + 1)) - 64'd1);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("occ8_reset", b8.occupancy, 8'h00);
    chk("door8_reset", b8.door_open, 1'b0);
    chk("free8_reset", b8.free_count, 4'd8);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 chk("free8_count", b8.free_count, 64'(7 - i));
    end
    chk("occ8_full", b8.occupancy, 8'hff);
    chk("full8_light", b8.full_light, 1'b1);
    chk("best8_valid", b8.best_valid, 1'b0);
    chk("best8_slot", b8.best_slot, 3'd0);
    @(posedge clk);
    #1 chk("rej8_full", b8.entry_rejected, 1'b1);
    @(negedge clk);
    b8.entry_sensor = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/parking_slot_manager.md
Name: parking_slot_manager

Overview:
- Parametrised successor to the 4-slot parking FSM. Tracks occupancy of NUM_SLOTS slots and allocates the lowest-index free slot on entry.
- Frees a named slot on exit and drives a timed door and a full indicator.
- Handles simultaneous entry and exit in one cycle, and flags invalid exits.
- Sits between the gate sensor front-end and the display/stats logic.

Parameters:
- NUM_SLOTS, 8, number of parking slots (2..64).
- SLOT_W, $clog2(NUM_SLOTS), width of slot index (derived; do not override).
- DOOR_HOLD, 4, cycles door_open stays high after an accepted event (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  when low: sensors ignored, all state and timers frozen.
- entry_sensor  in  1  one-cycle pulse = one car requesting entry.
- exit_sensor  in  1  one-cycle pulse = one car leaving.
- exit_location  in  SLOT_W  slot index vacated; sampled only with exit_sensor.
- occupancy  out  NUM_SLOTS  registered occupancy; bit i = slot i taken.
- free_count  out  SLOT_W+1  number of zero bits in occupancy (registered).
- best_slot  out  SLOT_W  lowest free index of occupancy; 0 when full (combinational from occupancy).
- best_valid  out  1  high when any slot is free.
- door_open  out  1  door drive, registered.
- full_light  out  1  registered; high while free_count == 0.
- entry_rejected  out  1  one-cycle pulse: entry refused, lot full.
- exit_error  out  1  one-cycle pulse: exit at an already-empty slot, or index >= NUM_SLOTS.
- stat_entries  out  16  accepted entries (see Optional Feature).
- stat_exits  out  16  accepted exits (see Optional Feature).

Behaviour:
- Reset (sync, priority over enable):
  - occupancy=0, free_count=NUM_SLOTS, door_open=0, full_light=0.
  - entry_rejected=0, exit_error=0, door timer=0, stat counters=0.
- All events are evaluated only on a rising clk edge with enable=1. With enable=0, every register holds, including the door timer.
- Exit:
  - Accepted if exit_location < NUM_SLOTS and occupancy[exit_location]=1.
  - Accepted: that bit is cleared on the next edge.
  - Otherwise: occupancy is unchanged and exit_error pulses 1 cycle.
- Entry allocation:
  - The candidate vector is occupancy with the accepted exit bit already cleared.
  - Entry takes the lowest zero bit of the candidate vector, set on the same edge.
  - Simultaneous exit+entry on a full lot is therefore accepted: the car takes the freed slot, and full_light stays high.
- Rejected entry: if the candidate vector is all ones, the entry is refused. entry_rejected pulses 1 cycle and occupancy is unchanged.
- free_count and full_light update on the same edge as occupancy (zero latency vs occupancy). free_count changes by -1, 0 or +1 per cycle.
- Door FSM, states IDLE / OPEN:
  - Any accepted entry or exit loads timer=DOOR_HOLD and enters OPEN.
  - door_open=1 from the cycle after the event for exactly DOOR_HOLD cycles.
  - A new accepted event while OPEN reloads the timer (extends); no glitch low.
  - Timer reaches 0 -> IDLE, door_open=0.
  - Rejected and error events do not open the door.
- best_slot/best_valid are pure functions of registered occupancy. They are valid the same cycle, for display.

Optional Feature:
- Macro PARKING_STATS_EN.
- Defined:
  - stat_entries and stat_exits count accepted entries and exits respectively.
  - Each is 16-bit, wraps at 65535 -> 0, and increments on the same edge as occupancy.
  - Both count a simultaneous entry+exit in the same cycle.
  - Both clear on reset and hold while enable=0.
- Not defined: both ports are tied to constant 0 and no counter registers are synthesised.

Test Plan (NUM_SLOTS=4, DOOR_HOLD=3 unless stated):
- Reset, then 4 entry pulses on consecutive cycles -> occupancy 0001, 0011, 0111, 1111; free_count 3,2,1,0; full_light=1 after 4th edge; door_open high continuously until 3 cycles after last entry.
- Full lot, entry pulse -> entry_rejected=1 one cycle; occupancy stays 1111; door_open stays 0.
- occupancy=1111, exit_sensor=1 with exit_location=2 plus entry_sensor=1 same cycle -> occupancy stays 1111; free_count=0; door_open 3 cycles; with PARKING_STATS_EN both stats +1.
- occupancy=0101, exit at location 1 -> exit_error pulse, occupancy 0101. Then exit at 2 -> occupancy 0001, best_slot=1, free_count=3.
- Entry, then enable=0 for 5 cycles mid-door-hold, then enable=1 -> door_open held through the freeze, drops after the remaining hold cycles; entries during the freeze ignored.
- NUM_SLOTS=8 build, 8 entries, reset asserted mid-sequence -> next edge occupancy=0, door_open=0, free_count=8.
